sccb_cfg_sequencer: RTL and testbench

//  Parametrised ROM-driven camera register loader. It walks a synchronous command ROM and

---
 rtl/sccb_cfg_pkg.sv | 43 ++++
 rtl/cfg_countdown.sv | 32 +++
 rtl/sccb_cfg_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_sccb_cfg_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared types and helpers for the SCCB configuration sequencer.
package sccb_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DLY,
        S_ISSUE,
        S_ACCEPT,
        S_XFER,
        S_DONE,
        S_ERROR
    } state_t;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // True when the low w bits of v are all ones.
    function automatic logic all_ones(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v & mask) == mask;
    endfunction

    // END marker: address field and data field both all ones.
    function automatic logic is_end(input logic [63:0] a, input logic [63:0] d,
                                    input int unsigned aw, input int unsigned dw);
        return all_ones(a, aw) && all_ones(d, dw);
    endfunction

    // DELAY entry: address field all ones, data field anything else.
    function automatic logic is_delay(input logic [63:0] a, input logic [63:0] d,
                                      input int unsigned aw, input int unsigned dw);
        return all_ones(a, aw) && !all_ones(d, dw);
    endfunction

endpackage

// File: rtl/cfg_countdown.sv
// Loadable down-counter that saturates at zero and flags it.
module cfg_countdown #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority over counting; counting stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks a command ROM and issues register writes to an SCCB/I2C master, with
// in-ROM delays, NACK retry, a per-transaction watchdog and error reporting.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned REG_AW      = 8,
    parameter int unsigned REG_DW      = 8,
    parameter int unsigned ROM_AW      = 8,
    parameter int unsigned ROM_LAT     = 1,
    parameter int unsigned DELAY_TICKS = 25000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [REG_AW+REG_DW-1:0] rom_data,
    input  logic                     sccb_ready,
    input  logic                     sccb_nack,
    output logic [REG_AW-1:0]        sccb_addr,
    output logic [REG_DW-1:0]        sccb_data,
    output logic                     sccb_start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ROM_AW-1:0]        err_index,
    output logic [ROM_AW:0]          cmd_count
);

    localparam int unsigned DLY_W = REG_DW + clog2(DELAY_TICKS) + 1;
    localparam int unsigned WD_W  = clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned LAT_W = clog2(ROM_LAT) + 1;
    localparam int unsigned RTY_W = clog2(MAX_RETRY + 1) + 1;
    localparam int unsigned CNT_W = ROM_AW + 1;
    localparam logic [ROM_AW-1:0] LAST_ADDR = '1;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(ROM_LAT - 1);
    localparam logic [WD_W-1:0]   WD_INIT   = WD_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [LAT_W-1:0]    fetch_q, fetch_d;
    logic [REG_AW-1:0]   sccb_addr_q, sccb_addr_d;
    logic [REG_DW-1:0]   sccb_data_q, sccb_data_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0]    cmd_count_q, cmd_count_d;
    logic [ROM_AW-1:0]   err_index_q, err_index_d;

    logic                dly_load, dly_en, dly_zero;
    logic                wd_load, wd_en, wd_zero;
    logic                advance, attempt_fail;
    logic [DLY_W-1:0]    dly_val;

    logic [REG_AW-1:0]   f_addr;
    logic [REG_DW-1:0]   f_data;

    assign f_addr  = rom_data[REG_AW+REG_DW-1:REG_DW];
    assign f_data  = rom_data[REG_DW-1:0];
    // (data+1)*DELAY_TICKS cycles spent in DLY; counter is loaded with one less.
    assign dly_val = (DLY_W'(f_data) + DLY_W'(1)) * DLY_W'(DELAY_TICKS) - DLY_W'(1);

    cfg_countdown #(.W(DLY_W)) u_dly (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (dly_load),
        .val_i  (dly_val),
        .en_i   (dly_en),
        .zero_o (dly_zero)
    );

    cfg_countdown #(.W(WD_W)) u_wd (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (wd_load),
        .val_i  (WD_INIT),
        .en_i   (wd_en),
        .zero_o (wd_zero)
    );

    // Next-state logic; ack/delay completion and failed attempts are resolved after the case.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        fetch_d      = fetch_q;
        sccb_addr_d  = sccb_addr_q;
        sccb_data_d  = sccb_data_q;
        retry_d      = retry_q;
        cmd_count_d  = cmd_count_q;
        err_index_d  = err_index_q;
        dly_load     = 1'b0;
        dly_en       = 1'b0;
        wd_load      = 1'b0;
        wd_en        = 1'b0;
        advance      = 1'b0;
        attempt_fail = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = S_FETCH;
                    rom_addr_d  = '0;
                    cmd_count_d = '0;
                    retry_d     = '0;
                    fetch_d     = LAT_INIT;
                end
            end
            S_FETCH: begin
                if (fetch_q == '0) state_d = S_DECODE;
                else               fetch_d = fetch_q - LAT_W'(1);
            end
            S_DECODE: begin
                if (is_end(64'(f_addr), 64'(f_data), REG_AW, REG_DW)) begin
                    state_d = S_DONE;
                end else if (is_delay(64'(f_addr), 64'(f_data), REG_AW, REG_DW)) begin
                    dly_load = 1'b1;
                    state_d  = S_DLY;
                end else begin
                    // Latch the write so retries do not depend on the ROM output.
                    sccb_addr_d = f_addr;
                    sccb_data_d = f_data;
                    wd_load     = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_DLY: begin
                dly_en = 1'b1;
                if (dly_zero) advance = 1'b1;
            end
            S_ISSUE: begin
                wd_en = 1'b1;
                if (sccb_ready)   state_d      = S_ACCEPT;
                else if (wd_zero) attempt_fail = 1'b1;
            end
            S_ACCEPT: begin
                wd_en = 1'b1;
                if (!sccb_ready)  state_d      = S_XFER;
                else if (wd_zero) attempt_fail = 1'b1;
            end
            S_XFER: begin
                wd_en = 1'b1;
                if (sccb_ready) begin
                    if (!sccb_nack) begin
                        cmd_count_d = cmd_count_q + CNT_W'(1);
                        advance     = 1'b1;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (wd_zero) begin
                    attempt_fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            retry_d = '0;
            if (rom_addr_q == LAST_ADDR) begin
                state_d = S_DONE;
            end else begin
                rom_addr_d = rom_addr_q + ROM_AW'(1);
                fetch_d    = LAT_INIT;
                state_d    = S_FETCH;
            end
        end

        if (attempt_fail) begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
                retry_d = retry_q + RTY_W'(1);
                wd_load = 1'b1;
                state_d = S_ISSUE;
            end else begin
                err_index_d = rom_addr_q;
                state_d     = S_ERROR;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            fetch_q     <= '0;
            sccb_addr_q <= '0;
            sccb_data_q <= '0;
            retry_q     <= '0;
            cmd_count_q <= '0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            fetch_q     <= fetch_d;
            sccb_addr_q <= sccb_addr_d;
            sccb_data_q <= sccb_data_d;
            retry_q     <= retry_d;
            cmd_count_q <= cmd_count_d;
            err_index_q <= err_index_d;
        end
    end

    // Request is qualified by ready inside ISSUE, so it lasts exactly the accepting cycle.
    assign sccb_start = (state_q == S_ISSUE) && sccb_ready;
    assign rom_addr   = rom_addr_q;
    assign sccb_addr  = sccb_addr_q;
    assign sccb_data  = sccb_data_q;
    assign busy       = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign err_index  = err_index_q;
    assign cmd_count  = cmd_count_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer with a scoreboard of expected writes.
module tb_sccb_cfg_sequencer;

    localparam int unsigned ROM_AW  = 4;
    localparam int unsigned ROM_LAT = 2;
    localparam int unsigned DT      = 10;
    localparam int unsigned MR      = 3;
    localparam int unsigned TO      = 100;
    localparam int unsigned BUSY    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sccb_ready, sccb_nack;
    logic [7:0]        sccb_addr, sccb_data;
    logic              sccb_start, busy, done, error;
    logic [ROM_AW-1:0] err_index;
    logic [ROM_AW:0]   cmd_count;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    logic [15:0] rom [16];
    logic [15:0] rd1, rd2;
    logic [15:0] exp_q[$];
    bit          nack_q[$];
    int unsigned st_cyc[$];
    bit          stuck_low = 1'b0;
    bit          pend_nack = 1'b0;
    int unsigned bcnt = 0;

    sccb_cfg_sequencer #(
        .REG_AW(8), .REG_DW(8), .ROM_AW(ROM_AW), .ROM_LAT(ROM_LAT),
        .DELAY_TICKS(DT), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_ready(sccb_ready), .sccb_nack(sccb_nack),
        .sccb_addr(sccb_addr), .sccb_data(sccb_data), .sccb_start(sccb_start),
        .busy(busy), .done(done), .error(error),
        .err_index(err_index), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM with ROM_LAT = 2 cycles of read latency.
    always @(posedge clk) begin
        rd1 <= rom[rom_addr];
        rd2 <= rd1;
    end
    assign rom_data = rd2;

    // SCCB master: accepts a request, stays busy BUSY cycles, then returns ack/nack.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sccb_ready <= 1'b1;
            sccb_nack  <= 1'b0;
            bcnt       <= 0;
        end else if (stuck_low) begin
            sccb_ready <= 1'b0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                sccb_ready <= 1'b1;
                sccb_nack  <= pend_nack;
            end
        end else if (sccb_start) begin
            sccb_ready <= 1'b0;
            bcnt       <= BUSY;
            if (nack_q.size() != 0) pend_nack <= nack_q.pop_front();
            else                    pend_nack <= 1'b0;
        end else begin
            sccb_ready <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every request is compared against the oldest expected write.
    always @(negedge clk) begin
        if (!rst && sccb_start) begin
            logic [63:0] expv;
            st_cyc.push_back(cyc);
            if (exp_q.size() != 0) expv = {48'h0, exp_q.pop_front()};
            else                   expv = 64'hDEAD_BEEF;
            check("sccb_write", {48'h0, sccb_addr, sccb_data}, expv);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rom_fill_end();
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic pulse_start(output int unsigned t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (st_cyc.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_write", 64'(st_cyc.size() >= target), 64'd1);
    endtask

    task automatic wait_end(input int budget, output int unsigned t);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        check("wait_end", 64'(done || error), 64'd1);
    endtask

    initial begin
        int unsigned t0, t1;

        rom_fill_end();
        tick(3);
        check("reset_outputs",
              {busy, done, error, sccb_start, rom_addr, cmd_count, err_index, sccb_addr, sccb_data},
              64'h0);
        rst = 1'b0;
        tick(2);

        // 1: two writes then END; a start pulse while busy must be ignored.
        rom_fill_end();
        rom[0] = 16'h1280; rom[1] = 16'h1100;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
        st_cyc.delete();
        pulse_start(t0);
        check("t1_busy_after_start", {busy, done, error, rom_addr}, {1'b1, 1'b0, 1'b0, 4'h0});
        wait_writes(1, 50);
        pulse_start(t1);
        wait_end(500, t1);
        check("t1_done_err", {done, error, busy}, 3'b100);
        check("t1_cmd_count", cmd_count, 2);
        check("t1_latency", st_cyc[0] - t0, 1 + ROM_LAT + 1);
        check("t1_gap", st_cyc[1] - st_cyc[0], BUSY + ROM_LAT + 3);
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: delay entry FF04 = 5 units of DT cycles between the two writes.
        rom_fill_end();
        rom[0] = 16'h1280; rom[1] = 16'hFF04; rom[2] = 16'h1100;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
        st_cyc.delete();
        pulse_start(t0);
        wait_end(500, t1);
        check("t2_done", {done, error}, 2'b10);
        check("t2_cmd_count", cmd_count, 2);
        check("t2_writes", st_cyc.size(), 2);
        check("t2_gap", st_cyc[1] - st_cyc[0], (BUSY + ROM_LAT + 3) + (ROM_LAT + 1) + 5 * DT);

        // 3: two NACKs then ack; same entry issued three times.
        rom_fill_end();
        rom[0] = 16'h1280;
        nack_q.push_back(1'b1); nack_q.push_back(1'b1); nack_q.push_back(1'b0);
        repeat (3) exp_q.push_back(16'h1280);
        st_cyc.delete();
        pulse_start(t0);
        wait_end(500, t1);
        check("t3_done", {done, error}, 2'b10);
        check("t3_cmd_count", cmd_count, 1);
        check("t3_attempts", st_cyc.size(), 3);

        // 4: permanent NACK on entry 2.
        rom_fill_end();
        rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'h3344;
        nack_q.push_back(1'b0); nack_q.push_back(1'b0);
        repeat (4) nack_q.push_back(1'b1);
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
        repeat (4) exp_q.push_back(16'h3344);
        st_cyc.delete();
        pulse_start(t0);
        wait_end(800, t1);
        check("t4_err_flags", {done, error, busy}, 3'b010);
        check("t4_err_index", err_index, 2);
        check("t4_cmd_count", cmd_count, 2);
        check("t4_attempts", st_cyc.size(), 6);

        // 5: ready stuck low; every attempt times out.
        rom_fill_end();
        rom[0] = 16'h1280;
        nack_q.delete();
        stuck_low = 1'b1;
        st_cyc.delete();
        pulse_start(t0);
        wait_end(1000, t1);
        check("t5_err_flags", {done, error, busy}, 3'b010);
        check("t5_err_index", err_index, 0);
        check("t5_err_time", t1 - t0, 1 + ROM_LAT + 1 + (MR + 1) * TO);
        check("t5_no_writes", st_cyc.size(), 0);
        stuck_low = 1'b0;
        tick(2);

        // 7: no END in the ROM; the last entry finishes the run without wrapping.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] n4;
            n4 = 4'(i);
            rom[i] = {4'h1, n4, 4'h0, n4};
            exp_q.push_back({4'h1, n4, 4'h0, n4});
        end
        st_cyc.delete();
        pulse_start(t0);
        wait_end(2000, t1);
        check("t7_done", {done, error}, 2'b10);
        check("t7_cmd_count", cmd_count, 16);
        check("t7_rom_addr_last", rom_addr, 15);
        check("t7_sb_empty", exp_q.size(), 0);

        // 6: reset in the middle of entry 1's transfer, then restart.
        rom_fill_end();
        rom[0] = 16'h1280; rom[1] = 16'h1100;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
        st_cyc.delete();
        pulse_start(t0);
        wait_writes(2, 100);
        tick(3);
        rst = 1'b1;
        #1;
        check("t6_reset_outputs",
              {busy, done, error, sccb_start, rom_addr, cmd_count, sccb_addr, sccb_data},
              64'h0);
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
        st_cyc.delete();
        pulse_start(t0);
        check("t6_restart", {busy, rom_addr}, {1'b1, 4'h0});
        wait_end(500, t1);
        check("t6_done", {done, error}, 2'b10);
        check("t6_cmd_count", cmd_count, 2);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
